// File: rtl/fact_bus_if.sv
// CPU-facing register window for the factorial accelerator: holds the operand,
// pulses go to the core, and latches result plus sticky done/err status.
module fact_bus_if #(
    parameter int N_WIDTH    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [1:0]            a,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd,
    output logic [N_WIDTH-1:0]    fact_n,
    output logic                  fact_go,
    input  logic                  fact_done,
    input  logic                  fact_error,
    input  logic [DATA_WIDTH-1:0] fact_result
);

    localparam logic [1:0] A_N      = 2'd0;
    localparam logic [1:0] A_GO     = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GO      = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [N_WIDTH-1:0]    n_q, n_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy;

    assign busy   = (state_q != S_IDLE);
    assign fact_n = n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Bus writes only land in IDLE, so the operand is frozen for a whole run.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;
        fact_go  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (we && a == A_N) begin
                    n_d = wd[N_WIDTH-1:0];
                end
                if (we && a == A_GO && wd[0]) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_GO;
                end
            end
            S_GO: begin
                fact_go = 1'b1;
                if (fact_done && fact_error) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fact_done) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                result_d = fact_result;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd = '0;
        case (a)
            A_N:      rd[N_WIDTH-1:0] = n_q;
            A_GO:     rd[0] = busy;
            A_STATUS: begin
                rd[0] = done_q;
                rd[1] = err_q;
                rd[2] = busy;
            end
            A_RESULT: rd = result_q;
            default:  rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_bus_if.sv
// Directed bench for fact_bus_if with a small behavioural factorial core attached.
module tb_fact_bus_if;

    localparam int NW = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          we;
    logic [1:0]    a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic [NW-1:0] fact_n;
    logic          fact_go;
    logic          fact_done;
    logic          fact_error;
    logic [DW-1:0] fact_result;

    int n_vectors;
    int n_miscompares;
    int go_pulses;

    fact_bus_if #(.N_WIDTH(NW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .a           (a),
        .wd          (wd),
        .rd          (rd),
        .fact_n      (fact_n),
        .fact_go     (fact_go),
        .fact_done   (fact_done),
        .fact_error  (fact_error),
        .fact_result (fact_result)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural core: idle reports done; n > 12 is rejected in the go cycle
    logic          core_busy;
    int            core_cnt;
    logic [DW-1:0] core_res;

    function automatic logic [DW-1:0] fact_fn(input int n);
        logic [DW-1:0] r;
        r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    assign fact_done   = !core_busy;
    assign fact_error  = fact_go && (fact_n > 4'd12);
    assign fact_result = core_res;

    always @(posedge clk) begin
        if (fact_go) go_pulses++;
        if (rst) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_res  <= '0;
        end else if (fact_go && !fact_error) begin
            core_busy <= 1'b1;
            core_cnt  <= int'(fact_n) + 2;
            core_res  <= fact_fn(int'(fact_n));
        end else if (core_busy) begin
            if (core_cnt <= 1) core_busy <= 1'b0;
            core_cnt <= core_cnt - 1;
        end
    end

    // checking
    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers: all called from the falling edge
    task automatic bus_write(input logic [1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = addr;
        wd = data;
        @(negedge clk);
        we = 1'b0;
        wd = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [DW-1:0] data);
        a = addr;
        #1;
        data = rd;
    endtask

    task automatic wait_idle(input string tag);
        logic [DW-1:0] st;
        bit            idle;
        idle = 1'b0;
        for (int i = 0; i < 64 && !idle; i++) begin
            @(negedge clk);
            bus_read(2'd2, st);
            if (st[2] == 1'b0) idle = 1'b1;
        end
        check_eq(tag, {31'b0, idle}, 32'd1);
    endtask

    task automatic run_op(input logic [NW-1:0] n, input logic [DW-1:0] exp_res, input string tag);
        logic [DW-1:0] v;
        int            g0;
        bus_write(2'd0, DW'(n));
        g0 = go_pulses;
        bus_write(2'd1, 32'd1);
        check_eq({tag, "_go_hi"}, {31'b0, fact_go}, 32'd1);
        bus_read(2'd2, v);
        check_eq({tag, "_busy_status"}, v, 32'h4);
        wait_idle({tag, "_idle"});
        bus_read(2'd2, v);
        check_eq({tag, "_status"}, v, 32'h1);
        bus_read(2'd3, v);
        check_eq({tag, "_result"}, v, exp_res);
        check_eq({tag, "_pulses"}, DW'(go_pulses - g0), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] v;
        int            g0;
        n_vectors     = 0;
        n_miscompares = 0;
        go_pulses     = 0;
        rst = 1'b1;
        we  = 1'b0;
        a   = 2'd0;
        wd  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        bus_read(2'd2, v); check_eq("rst_status", v, 32'h0);
        bus_read(2'd3, v); check_eq("rst_result", v, 32'h0);
        bus_read(2'd0, v); check_eq("rst_n", v, 32'h0);
        bus_read(2'd1, v); check_eq("rst_go_rd", v, 32'h0);
        check_eq("rst_fact_go", {31'b0, fact_go}, 32'd0);

        // N=5 -> 120, go pulse is one cycle only
        bus_write(2'd0, 32'd5);
        bus_read(2'd0, v); check_eq("n_readback", v, 32'd5);
        check_eq("fact_n_5", DW'(fact_n), 32'd5);
        g0 = go_pulses;
        bus_write(2'd1, 32'd1);
        check_eq("n5_go_hi", {31'b0, fact_go}, 32'd1);
        bus_read(2'd1, v); check_eq("n5_go_rd_busy", v, 32'd1);
        @(negedge clk);
        check_eq("n5_go_lo", {31'b0, fact_go}, 32'd0);
        wait_idle("n5_idle");
        bus_read(2'd2, v); check_eq("n5_status", v, 32'h1);
        bus_read(2'd3, v); check_eq("n5_result", v, 32'd120);
        check_eq("n5_pulses", DW'(go_pulses - g0), 32'd1);

        // GO with wd[0]=0 and writes to RO registers are ignored
        bus_write(2'd1, 32'hFFFF_FFFE);
        check_eq("go0_no_pulse", {31'b0, fact_go}, 32'd0);
        bus_write(2'd3, 32'hDEAD_BEEF);
        bus_write(2'd2, 32'h0);
        bus_read(2'd2, v); check_eq("ro_status", v, 32'h1);
        bus_read(2'd3, v); check_eq("ro_result", v, 32'd120);

        // N=0 -> 1
        run_op(4'd0, 32'd1, "n0");

        // N=13 rejected in the go cycle
        bus_write(2'd0, 32'd13);
        g0 = go_pulses;
        bus_write(2'd1, 32'd1);
        check_eq("n13_go_hi", {31'b0, fact_go}, 32'd1);
        bus_read(2'd2, v); check_eq("n13_busy", v, 32'h4);
        @(negedge clk);
        bus_read(2'd2, v); check_eq("n13_status", v, 32'h3);
        bus_read(2'd3, v); check_eq("n13_result_kept", v, 32'd1);
        check_eq("n13_core_idle", {31'b0, fact_done}, 32'd1);
        repeat (3) @(negedge clk);
        check_eq("n13_pulses", DW'(go_pulses - g0), 32'd1);

        // writes while busy are ignored
        bus_write(2'd0, 32'd5);
        g0 = go_pulses;
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'd3);
        bus_write(2'd1, 32'd1);
        check_eq("busy_fact_n", DW'(fact_n), 32'd5);
        bus_read(2'd0, v); check_eq("busy_n_rd", v, 32'd5);
        wait_idle("busy_idle");
        bus_read(2'd3, v); check_eq("busy_result", v, 32'd120);
        check_eq("busy_pulses", DW'(go_pulses - g0), 32'd1);

        // reset during WAIT
        bus_write(2'd1, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'd2, v); check_eq("midrst_status", v, 32'h0);
        bus_read(2'd3, v); check_eq("midrst_result", v, 32'h0);
        bus_read(2'd0, v); check_eq("midrst_n", v, 32'h0);
        check_eq("midrst_fact_go", {31'b0, fact_go}, 32'd0);
        run_op(4'd4, 32'd24, "n4");

        // back-to-back runs
        run_op(4'd3, 32'd6, "n3");
        run_op(4'd6, 32'd720, "n6");

        // start write coincident with reset resolves to reset
        @(negedge clk);
        we = 1'b1; a = 2'd1; wd = 32'd1; rst = 1'b1;
        @(negedge clk);
        we = 1'b0; rst = 1'b0;
        check_eq("rstwr_fact_go", {31'b0, fact_go}, 32'd0);
        bus_read(2'd2, v); check_eq("rstwr_status", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
